ysyx_23060332_exu_mc: RTL and testbench
=======================================

YSYX_23060332_EXU_MC -- requirements
Module: ysyx_23060332_exu_mc

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  abort in-flight operation; synchronous.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 inst_i  input  32  instruction; opcode [6:0], func3 [14:12], func7 [31:25].
REQ-008 op1, op2  input  XLEN each  operands; op2 is the register value or the sign-extended immediate.
REQ-009 waddr_i  input  5  destination register.
REQ-010 reg_wen_i  input  1  destination write request.
REQ-011 out_valid  output  1  result held.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 wdata  output  XLEN  result.
REQ-014 waddr_o  output  5  registered copy of waddr_i.
REQ-015 reg_wen_o  output  1  registered reg_wen_i, qualified by out_valid.
REQ-016 illegal_o  output  1  request not supported; valid with out_valid.

Function
REQ-017 FSM states: IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-018 Accept occurs on in_valid&&in_ready; inst_i, op1, op2, waddr_i and reg_wen_i are captured on that edge.
REQ-019 OP (0110011, func7 0000000/0100000) and OP-IMM (0010011) ALU ops SHALL be add, sub, sll, slt, sltu, xor, srl, sra, or and and; the result is registered, IDLE goes to DONE, and latency is 1 cycle.
REQ-020 Shift amount SHALL be op2[$clog2(XLEN)-1:0]; sra is selected by inst_i[30]; sub applies only to OP.
REQ-021 M ops (OP, func7 0000001) mul, mulh, mulhsu and mulhu SHALL use an iterative shift-add multiplier: one partial product per cycle, XLEN cycles in BUSY, then DONE; latency XLEN+1.
REQ-022 mulh, mulhsu and mulhu SHALL return the high XLEN bits of the 2*XLEN product with signedness per RISC-V; mul returns the low XLEN bits.
REQ-023 div, divu, rem and remu SHALL use an iterative restoring divider: XLEN cycles in BUSY, latency XLEN+1; signed ops operate on magnitudes with sign-corrected results.
REQ-024 Divisor zero SHALL complete in 1 cycle with quotient all-ones and remainder op1.
REQ-025 Signed overflow (op1=-2^(XLEN-1), op2=-1) SHALL complete in 1 cycle with quotient op1 and remainder 0.
REQ-026 Any other opcode/func combination SHALL complete in 1 cycle with wdata 0, reg_wen_o 0 and illegal_o 1.
REQ-027 In DONE, outputs SHALL hold stable until out_valid&&out_ready, then go to IDLE; no new accept occurs in the same cycle.
REQ-028 waddr_o=0 SHALL force reg_wen_o to 0.
REQ-029 flush SHALL force IDLE next cycle from any state and drop the result; flush has priority over accept and completion.

Reset
REQ-030 While rst is high, the next edge SHALL set: state IDLE, out_valid 0, wdata 0, waddr_o 0, reg_wen_o 0, illegal_o 0, and iteration counter 0.
REQ-031 rst mid-BUSY or mid-DONE SHALL discard the operation; rst has priority over flush.

Configuration
REQ-032 Macro YSYX_23060332_DIV_EN: when defined, the divider and REQ-023..025 SHALL be present.
REQ-033 When YSYX_23060332_DIV_EN is undefined, div/divu/rem/remu SHALL be treated per REQ-026 (illegal, 1 cycle) and no divider logic is present.

Verification
REQ-034 XLEN=32; sub with op1=5, op2=7 -> out_valid 1 cycle after accept, wdata 0xFFFFFFFE.
REQ-035 mulhu with op1=op2=0xFFFFFFFF -> out_valid 33 cycles after accept, wdata 0xFFFFFFFE; mul on the same operands gives 0x00000001.
REQ-036 With DIV_EN: div 0x80000000 / 0xFFFFFFFF -> 1 cycle, wdata 0x80000000; rem 7 / 0 -> 1 cycle, wdata 7; divu 100 / 7 -> 33 cycles, wdata 14.
REQ-037 out_ready held 0 for 5 cycles in DONE -> wdata, waddr_o and out_valid stable; in_ready 0 throughout.
REQ-038 flush asserted 10 cycles into mul BUSY -> IDLE next cycle, out_valid never asserted, next add accepted normally.
REQ-039 Without DIV_EN: divu -> 1 cycle, illegal_o 1, reg_wen_o 0, wdata 0; XLEN=64 sra of 0x8000000000000000 by 63 -> all-ones.

Source files
------------

// File: rtl/ysyx_23060332_exu_mc.sv
// Multi-cycle execute unit: RV ALU (1 cycle), iterative shift-add multiplier, optional restoring divider.
// Latency: ALU/illegal/divide special cases 1 cycle, multiply and divide XLEN+1 cycles from accept.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_valid && out_ready.
//
// Ports:
//   clk, rst (sync, active-high), flush (sync abort, drops any result)
//   in_valid/in_ready, inst_i, op1, op2, waddr_i, reg_wen_i   request side
//   out_valid/out_ready, wdata, waddr_o, reg_wen_o, illegal_o  result side
// Build option: define YSYX_23060332_DIV_EN to include div/divu/rem/remu; otherwise they
// complete as illegal instructions.
module ysyx_23060332_exu_mc #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [4:0]      waddr_i,
    input  logic            reg_wen_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] wdata,
    output logic [4:0]      waddr_o,
    output logic            reg_wen_o,
    output logic            illegal_o
);

    localparam int SW = $clog2(XLEN);
    localparam int DW = 2 * XLEN;
    localparam logic [SW-1:0] LAST = SW'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
    typedef enum logic [1:0] {K_MULL, K_MULH, K_DIVQ, K_DIVR} kind_e;

    state_e          state_q, state_d;
    kind_e           kind_q, kind_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   acc_q, acc_d;       // product accumulator / divider remainder
    logic [DW-1:0]   mcand_q, mcand_d;   // shifted multiplicand / divisor in low half
    logic [XLEN-1:0] mplier_q, mplier_d; // multiplier bits / dividend shifting into quotient
    logic            neg_q, neg_d;       // negate the final magnitude
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [4:0]      waddr_q, waddr_d;
    logic            wen_q, wen_d;
    logic            illegal_q, illegal_d;

    // ---------------- decode ----------------
    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic       is_op, is_imm, alu_ok, is_m, is_mul;
    logic       unused_bits;

    assign opcode = inst_i[6:0];
    assign f3     = inst_i[14:12];
    assign f7     = inst_i[31:25];
    assign is_op  = (opcode == 7'b0110011);
    assign is_imm = (opcode == 7'b0010011);
    // The alternate encoding (func7 0100000) only exists for sub and sra.
    assign alu_ok = is_imm ||
                    (is_op && ((f7 == 7'b0000000) ||
                               ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)))));
    assign is_m   = is_op && (f7 == 7'b0000001);
    assign is_mul = is_m && !f3[2];
    assign unused_bits = ^{inst_i[24:15], inst_i[11:7]};

    // ---------------- single-cycle ALU ----------------
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] alu_res;
    assign shamt = op2[SW-1:0];

    always_comb begin
        alu_res = '0;
        case (f3)
            3'b000: alu_res = (is_op && inst_i[30]) ? op1 - op2 : op1 + op2;
            3'b001: alu_res = op1 << shamt;
            3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            3'b011: alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
            3'b100: alu_res = op1 ^ op2;
            3'b101: begin
                // kept as if/else so the arithmetic shift stays in a signed context
                if (inst_i[30]) alu_res = $signed(op1) >>> shamt;
                else            alu_res = op1 >> shamt;
            end
            3'b110: alu_res = op1 | op2;
            default: alu_res = op1 & op2;
        endcase
    end

    // ---------------- multiplier setup ----------------
    // Multiply runs on magnitudes; the sign is reapplied to the full 2*XLEN product.
    logic            ms1, ms2, mn1, mn2;
    logic [XLEN-1:0] mmag1, mmag2;
    assign ms1   = (f3 == 3'b001) || (f3 == 3'b010);
    assign ms2   = (f3 == 3'b001);
    assign mn1   = ms1 && op1[XLEN-1];
    assign mn2   = ms2 && op2[XLEN-1];
    assign mmag1 = mn1 ? -op1 : op1;
    assign mmag2 = mn2 ? -op2 : op2;

`ifdef YSYX_23060332_DIV_EN
    // ---------------- divider setup and step ----------------
    logic            is_div, ds, drem, dn1, dn2, div_zero, div_ovf, div_fits;
    logic [XLEN-1:0] dmag1, dmag2;
    logic [XLEN:0]   div_sh, div_diff;
    assign is_div   = is_m && f3[2];
    assign ds       = !f3[0];
    assign drem     = f3[1];
    assign dn1      = ds && op1[XLEN-1];
    assign dn2      = ds && op2[XLEN-1];
    assign dmag1    = dn1 ? -op1 : op1;
    assign dmag2    = dn2 ? -op2 : op2;
    assign div_zero = (op2 == '0);
    assign div_ovf  = ds && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
    // Restoring step: shift the next dividend bit into the partial remainder and
    // keep the subtraction only when it does not borrow.
    assign div_sh   = {acc_q[XLEN-1:0], mplier_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, mcand_q[XLEN-1:0]};
    assign div_fits = !div_diff[XLEN];
`endif

    // ---------------- iteration datapath ----------------
    logic [DW-1:0]   acc_nx, mcand_nx, prod;
    logic [XLEN-1:0] mplier_nx, fin_res;

    always_comb begin
        acc_nx    = acc_q;
        mcand_nx  = mcand_q;
        mplier_nx = mplier_q;
        if ((kind_q == K_MULL) || (kind_q == K_MULH)) begin
            if (mplier_q[0]) acc_nx = acc_q + mcand_q;
            mcand_nx  = mcand_q << 1;
            mplier_nx = mplier_q >> 1;
        end
`ifdef YSYX_23060332_DIV_EN
        else begin
            acc_nx    = {{XLEN{1'b0}}, div_fits ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]};
            mplier_nx = {mplier_q[XLEN-2:0], div_fits};
        end
`endif
    end

    // Final result uses the values of the last iteration, so the result is
    // registered on the same edge that leaves BUSY.
    always_comb begin
        prod    = neg_q ? -acc_nx : acc_nx;
        fin_res = prod[XLEN-1:0];   // mul low half; also the remainder (upper half zero)
        case (kind_q)
            K_MULH: fin_res = prod[DW-1:XLEN];
`ifdef YSYX_23060332_DIV_EN
            K_DIVQ: fin_res = neg_q ? -mplier_nx : mplier_nx;
`endif
            default: ;
        endcase
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        neg_d     = neg_q;
        wdata_d   = wdata_q;
        waddr_d   = waddr_q;
        wen_d     = wen_q;
        illegal_d = illegal_q;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        waddr_d   = waddr_i;
                        cnt_d     = '0;
                        illegal_d = 1'b0;
                        wen_d     = reg_wen_i && (waddr_i != 5'd0);
                        state_d   = S_DONE;
                        if (alu_ok) begin
                            wdata_d = alu_res;
                        end else if (is_mul) begin
                            acc_d    = '0;
                            mcand_d  = {{XLEN{1'b0}}, mmag1};
                            mplier_d = mmag2;
                            neg_d    = mn1 ^ mn2;
                            kind_d   = (f3 == 3'b000) ? K_MULL : K_MULH;
                            state_d  = S_BUSY;
                        end
`ifdef YSYX_23060332_DIV_EN
                        else if (is_div) begin
                            if (div_zero) begin
                                wdata_d = drem ? op1 : '1;
                            end else if (div_ovf) begin
                                wdata_d = drem ? '0 : op1;
                            end else begin
                                acc_d    = '0;
                                mcand_d  = {{XLEN{1'b0}}, dmag2};
                                mplier_d = dmag1;
                                // remainder takes the dividend's sign, quotient the xor
                                neg_d    = drem ? dn1 : (dn1 ^ dn2);
                                kind_d   = drem ? K_DIVR : K_DIVQ;
                                state_d  = S_BUSY;
                            end
                        end
`endif
                        else begin
                            wdata_d   = '0;
                            wen_d     = 1'b0;
                            illegal_d = 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    acc_d    = acc_nx;
                    mcand_d  = mcand_nx;
                    mplier_d = mplier_nx;
                    cnt_d    = cnt_q + SW'(1);
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        wdata_d = fin_res;
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            kind_q    <= K_MULL;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            neg_q     <= 1'b0;
            wdata_q   <= '0;
            waddr_q   <= '0;
            wen_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            neg_q     <= neg_d;
            wdata_q   <= wdata_d;
            waddr_q   <= waddr_d;
            wen_q     <= wen_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign wdata     = wdata_q;
    assign waddr_o   = waddr_q;
    assign reg_wen_o = wen_q && out_valid;
    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_ysyx_23060332_exu_mc.sv
// Scoreboard bench for ysyx_23060332_exu_mc: directed and random requests on an XLEN=32
// instance against a behavioural model, plus directed 64-bit shift/multiply cases.
module tb_ysyx_23060332_exu_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, in_ready, reg_wen_i, out_valid, out_ready, reg_wen_o, illegal_o;
    logic [31:0] inst, op1, op2, wdata;
    logic [4:0]  waddr_i, waddr_o;

    logic        flush64, in_valid64, in_ready64, reg_wen_i64, out_valid64, out_ready64, reg_wen_o64, illegal_o64;
    logic [31:0] inst64;
    logic [63:0] op1_64, op2_64, wdata64;
    logic [4:0]  waddr_i64, waddr_o64;

    ysyx_23060332_exu_mc #(.XLEN(32)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .inst_i(inst), .op1(op1), .op2(op2), .waddr_i(waddr_i), .reg_wen_i(reg_wen_i),
        .out_valid(out_valid), .out_ready(out_ready), .wdata(wdata), .waddr_o(waddr_o),
        .reg_wen_o(reg_wen_o), .illegal_o(illegal_o)
    );

    ysyx_23060332_exu_mc #(.XLEN(64)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush64), .in_valid(in_valid64), .in_ready(in_ready64),
        .inst_i(inst64), .op1(op1_64), .op2(op2_64), .waddr_i(waddr_i64), .reg_wen_i(reg_wen_i64),
        .out_valid(out_valid64), .out_ready(out_ready64), .wdata(wdata64), .waddr_o(waddr_o64),
        .reg_wen_o(reg_wen_o64), .illegal_o(illegal_o64)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] wdata;
        logic [4:0]  waddr;
        logic        wen;
        logic        ill;
        int          acc_cyc;
        int          lat;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] alu32(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'd0: r = alt ? a - b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: begin
                if (alt) r = $signed(a) >>> b[4:0];
                else     r = a >> b[4:0];
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic void model(input logic [31:0] iv, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic ill, output int lat);
        logic [6:0] opc, f7;
        logic [2:0] f3;
        logic signed [63:0] sp;
        logic [63:0] up;
        opc = iv[6:0];
        f3  = iv[14:12];
        f7  = iv[31:25];
        res = 32'd0;
        ill = 1'b0;
        lat = 1;
        if (opc == 7'h33 && f7 == 7'h01) begin
            if (!f3[2]) begin
                lat = 33;
                case (f3[1:0])
                    2'd0: res = a * b;
                    2'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); res = sp[63:32]; end
                    2'd2: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); res = sp[63:32]; end
                    default: begin up = {32'd0, a} * {32'd0, b}; res = up[63:32]; end
                endcase
            end else begin
`ifdef YSYX_23060332_DIV_EN
                if (b == 32'd0) begin
                    res = f3[1] ? a : 32'hFFFF_FFFF;
                end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    res = f3[1] ? 32'd0 : a;
                end else begin
                    lat = 33;
                    case (f3[1:0])
                        2'd0: res = $signed(a) / $signed(b);
                        2'd1: res = a / b;
                        2'd2: res = $signed(a) % $signed(b);
                        default: res = a % b;
                    endcase
                end
`else
                ill = 1'b1;
`endif
            end
        end else if (opc == 7'h33 && (f7 == 7'h00 || f7 == 7'h20)) begin
            if (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) ill = 1'b1;
            else res = alu32(f3, f7 == 7'h20, a, b);
        end else if (opc == 7'h13) begin
            res = alu32(f3, (f3 == 3'd5) && iv[30], a, b);
        end else begin
            ill = 1'b1;
        end
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
        return {f7, 10'($urandom), f3, 5'($urandom), opc};
    endfunction

    function automatic logic [31:0] rop();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- driver ----------------
    // Called on a negedge; returns on the negedge right after the accepting edge.
    task automatic issue(input logic [31:0] iv, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa, input logic we, input bit expect_out);
        int n;
        exp_t e;
        logic [31:0] res;
        logic ill;
        int lat;
        n = 0;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout in_ready=%b required=1", in_ready);
            return;
        end
        in_valid = 1'b1;
        inst = iv; op1 = a; op2 = b; waddr_i = wa; reg_wen_i = we;
        if (expect_out) begin
            model(iv, a, b, res, ill, lat);
            e.wdata = res; e.waddr = wa; e.ill = ill;
            e.wen = we && (wa != 5'd0) && !ill;
            e.acc_cyc = cyc; e.lat = lat;
            sbq.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        inst = $urandom; op1 = $urandom; op2 = $urandom;
    endtask

    // ---------------- monitor ----------------
    exp_t cur;
    bit   active = 1'b0;
    int   hold = 0;
    int   ntx = 0;
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (!active) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output wdata=%h required=no_output", wdata);
                        hold = 0;
                    end else begin
                        cur = sbq.pop_front();
                        active = 1'b1;
                        chk("latency", 64'(cyc - cur.acc_cyc), 64'(cur.lat));
                        // every fifth result (including the first) is stalled 5 cycles
                        hold = (ntx % 5 == 0) ? 5 : $urandom_range(0, 2);
                        ntx++;
                    end
                end
                if (active) begin
                    chk("wdata", 64'(wdata), 64'(cur.wdata));
                    chk("waddr_o", 64'(waddr_o), 64'(cur.waddr));
                    chk("reg_wen_o", 64'(reg_wen_o), 64'(cur.wen));
                    chk("illegal_o", 64'(illegal_o), 64'(cur.ill));
                    chk("in_ready_in_done", 64'(in_ready), 64'd0);
                end
                if (hold > 0) begin
                    out_ready = 1'b0;
                    hold--;
                end else begin
                    out_ready = 1'b1;
                    active = 1'b0;
                end
            end else begin
                out_ready = 1'($urandom);
                if (!rst) chk("reg_wen_o_idle", 64'(reg_wen_o), 64'd0);
            end
        end
    end

    // ---------------- 64-bit directed ----------------
    task automatic run64(input string nm, input logic [31:0] iv, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] expv, input int lat);
        int start, n;
        @(negedge clk);
        in_valid64 = 1'b1; inst64 = iv; op1_64 = a; op2_64 = b;
        waddr_i64 = 5'd9; reg_wen_i64 = 1'b1;
        start = cyc;
        @(negedge clk);
        in_valid64 = 1'b0;
        n = 0;
        while (!out_valid64 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid64) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout out_valid=0 required=1", nm);
        end else begin
            chk({nm, "_lat"}, 64'(cyc - start), 64'(lat));
            chk(nm, wdata64, expv);
            chk({nm, "_ill"}, 64'(illegal_o64), 64'd0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    // ---------------- main stimulus ----------------
    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; inst = '0; op1 = '0; op2 = '0;
        waddr_i = '0; reg_wen_i = 1'b0;
        flush64 = 1'b0; in_valid64 = 1'b0; inst64 = '0; op1_64 = '0; op2_64 = '0;
        waddr_i64 = '0; reg_wen_i64 = 1'b0; out_ready64 = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_wdata", 64'(wdata), 64'd0);
        chk("rst_waddr_o", 64'(waddr_o), 64'd0);
        chk("rst_reg_wen_o", 64'(reg_wen_o), 64'd0);
        chk("rst_illegal_o", 64'(illegal_o), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;

        // directed: sub (first result is stalled 5 cycles), mul family, divide cases
        issue(mk(7'h20, 3'd0, 7'h33), 32'd5, 32'd7, 5'd3, 1'b1, 1'b1);
        issue(mk(7'h01, 3'd3, 7'h33), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b1, 1'b1);
        issue(mk(7'h01, 3'd0, 7'h33), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1'b1, 1'b1);
        issue(mk(7'h01, 3'd5, 7'h33), 32'd100, 32'd7, 5'd6, 1'b1, 1'b1);
        issue(mk(7'h01, 3'd4, 7'h33), 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1'b1, 1'b1);
        issue(mk(7'h01, 3'd6, 7'h33), 32'd7, 32'd0, 5'd8, 1'b1, 1'b1);
        issue(mk(7'h00, 3'd0, 7'h33), 32'd1, 32'd2, 5'd0, 1'b1, 1'b1);

        // flush 10 cycles into a multiply: no result, then a normal add
        issue(mk(7'h01, 3'd0, 7'h33), 32'd3, 32'd9, 5'd10, 1'b1, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        issue(mk(7'h00, 3'd0, 7'h33), 32'd40, 32'd2, 5'd11, 1'b1, 1'b1);

        // reset in the middle of a multiply discards it and clears outputs
        issue(mk(7'h01, 3'd1, 7'h33), 32'd3, 32'd9, 5'd12, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy_wdata", 64'(wdata), 64'd0);
        chk("rst_busy_waddr_o", 64'(waddr_o), 64'd0);

        // random traffic
        for (int t = 0; t < 200; t++) begin
            logic [31:0] iv, a, b;
            logic [6:0]  f7, opc;
            logic [2:0]  f3;
            int          cat;
            cat = $urandom_range(0, 9);
            f3  = 3'($urandom);
            a   = rop();
            b   = rop();
            case (cat)
                0, 1, 2: begin
                    f7 = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00;
                    iv = mk(f7, f3, 7'h33);
                end
                3, 4: begin
                    if (f3 == 3'd1)      f7 = 7'h00;
                    else if (f3 == 3'd5) f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                    else                 f7 = 7'($urandom);
                    iv = mk(f7, f3, 7'h13);
                end
                7: begin
                    opc = 7'($urandom);
                    if (opc == 7'h33 || opc == 7'h13) opc = 7'h37;
                    iv = mk(7'($urandom), f3, opc);
                end
                8: begin
                    f7 = 7'($urandom);
                    if (f7 == 7'h00 || f7 == 7'h20 || f7 == 7'h01) f7 = 7'h7F;
                    iv = mk(f7, f3, 7'h33);
                end
                default: begin
                    iv = mk(7'h01, f3, 7'h33);
                    if (cat == 6 && $urandom_range(0, 2) == 0) begin
                        if ($urandom_range(0, 1) == 1) b = 32'd0;
                        else begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                    end
                end
            endcase
            issue(iv, a, b, 5'($urandom), 1'($urandom), 1'b1);
        end

        begin
            int n;
            n = 0;
            while ((sbq.size() != 0 || active) && n < 2000) begin
                @(negedge clk);
                n++;
            end
            chk("drain_pending", 64'(sbq.size()), 64'd0);
        end

        // 64-bit datapath
        run64("sra64", mk(7'h20, 3'd5, 7'h33), 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run64("srl64", mk(7'h00, 3'd5, 7'h33), 64'h8000_0000_0000_0000, 64'd63, 64'd1, 1);
        run64("srai64_mask", mk(7'h20, 3'd5, 7'h13), 64'h8000_0000_0000_0000, 64'h1_0000_0043,
              64'hF000_0000_0000_0000, 1);
        run64("sll64", mk(7'h00, 3'd1, 7'h33), 64'd1, 64'd40, 64'h0000_0100_0000_0000, 1);
        run64("mul64", mk(7'h01, 3'd0, 7'h33), 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 65);
        run64("mulhu64", mk(7'h01, 3'd3, 7'h33), 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFE, 65);
        run64("mulh64", mk(7'h01, 3'd1, 7'h33), 64'hFFFF_FFFF_FFFF_FFFD, 64'd5,
              64'hFFFF_FFFF_FFFF_FFFF, 65);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
